clock_set_controller: RTL

- Sequences the 24-hour clock datapath: generates the 1 Hz tick from the 1 MHz system clock.
- Drives increment strobes into the external sec/min/hr counters.
- Runs a user time-set FSM: mode button selects a field, inc button bumps the selected field.
- Counters own their values and wrap; this block only decides when each counter steps.

---
 rtl/clock_set_controller.sv | 126 ++++++++++++
 1 files changed

// File: rtl/clock_set_controller.sv
// Timing and time-set controller for the 24-hour clock: derives the 1 Hz tick
// and decides when the external sec/min/hr counters step.
module clock_set_controller #(
    parameter int TICK_DIV   = 1000000,
    parameter int BLINK_DIV  = 250000,
    parameter int IDLE_TICKS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       sec_tc,
    input  logic       min_tc,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       hr_inc,
    output logic       tick,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int IDLE_MAX = IDLE_TICKS * TICK_DIV;
    localparam int CW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int IW = $clog2(IDLE_MAX + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] blink_cnt;
    logic [IW-1:0] idle_cnt;
    logic          mode_q;
    logic          inc_q;
    logic          mode_rise;
    logic          inc_rise;
    logic          wrap;

    assign mode_rise = mode_btn & ~mode_q;
    assign inc_rise  = inc_btn & ~inc_q;
    assign wrap      = (cnt == CW'(TICK_DIV - 1));
    assign mode      = state;

    // History regs reset high so a button held through reset gives no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= '0;
            blink_cnt <= '0;
            idle_cnt  <= '0;
            mode_q    <= 1'b1;
            inc_q     <= 1'b1;
            sec_inc   <= 1'b0;
            min_inc   <= 1'b0;
            hr_inc    <= 1'b0;
            tick      <= 1'b0;
            blink     <= 1'b0;
        end else begin
            mode_q  <= mode_btn;
            inc_q   <= inc_btn;
            sec_inc <= 1'b0;
            min_inc <= 1'b0;
            hr_inc  <= 1'b0;
            tick    <= 1'b0;

            if (state == RUN) begin
                blink     <= 1'b0;
                blink_cnt <= '0;
                idle_cnt  <= '0;
                // The wrap strobes still go out when mode is pressed on the same edge.
                if (wrap) begin
                    cnt     <= '0;
                    tick    <= 1'b1;
                    sec_inc <= 1'b1;
                    min_inc <= sec_tc;
                    hr_inc  <= sec_tc & min_tc;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                if (mode_rise) begin
                    state     <= SET_HR;
                    cnt       <= '0;
                    blink     <= 1'b1;
                    blink_cnt <= '0;
                end
            end else begin
                cnt <= '0;
                if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end

                // Priority: mode press, then inc press, then inactivity timeout.
                if (mode_rise) begin
                    state     <= state_t'(state + 2'd1);
                    idle_cnt  <= '0;
                    blink_cnt <= '0;
                    blink     <= (state != SET_SEC);
                end else if (inc_rise) begin
                    idle_cnt <= '0;
                    case (state)
                        SET_HR:  hr_inc  <= 1'b1;
                        SET_MIN: min_inc <= 1'b1;
                        SET_SEC: sec_inc <= 1'b1;
                        default: ;
                    endcase
                end else if (idle_cnt == IW'(IDLE_MAX - 1)) begin
                    state     <= RUN;
                    idle_cnt  <= '0;
                    blink     <= 1'b0;
                    blink_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end
        end
    end

endmodule
